// File: rtl/f1_light_sequencer_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// FALSE_START_EN adds the FOUL state to the state enum.
package f1_pkg;

  localparam int unsigned LIGHT_CNT = 8;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned CNT_W     = 14;
  localparam int unsigned HOLD_W    = 12;
  localparam int unsigned EDGE_W    = 1;

  localparam logic [LFSR_W-1:0] LFSR_MASK      = 16'hB400;
  localparam logic [LFSR_W-1:0] HOLD_RAND_MASK = 16'h07FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIGHTS,
    S_HOLD,
    S_GO,
    S_DONE
`ifdef FALSE_START_EN
    , S_FOUL
`endif
  } state_t;

  // Right-shifting Galois step: the bit shifted out folds back through the mask.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {1'b0, x[LFSR_W-1:1]} ^ (x[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/f1_light_sequencer_if.sv
// Race-control signals between the sequencer and its surroundings.
interface f1_light_sequencer_if
  import f1_pkg::*;
;
  logic                 start;
  logic                 button;
  logic                 tick_ms;
  logic [LIGHT_CNT-1:0] ledr;
  logic                 reaction_trigger;
  logic                 false_start;
  logic                 timeout;
  logic                 busy;

  modport master (
    output start, button, tick_ms,
    input  ledr, reaction_trigger, false_start, timeout, busy
  );

  modport slave (
    input  start, button, tick_ms,
    output ledr, reaction_trigger, false_start, timeout, busy
  );
endinterface

// File: rtl/f1_light_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR supplying the random hold after the last light.
module f1_lfsr16
  import f1_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb q_d = lfsr_step(q_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: lights, random hold, GO window with timeout.
// Define FALSE_START_EN to abort a race on a press during LIGHTS/HOLD.
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int unsigned       LIGHT_MS     = 500,
  parameter int unsigned       DELAY_MIN_MS = 250,
  parameter int unsigned       TIMEOUT_MS   = 9999,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  f1_light_sequencer_if.slave io
);

  localparam logic [CNT_W-1:0]  LIGHT_LAST = CNT_W'(LIGHT_MS - 1);
  localparam logic [CNT_W-1:0]  GO_LAST    = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_BASE  = HOLD_W'(DELAY_MIN_MS);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LIGHT_CNT-1:0] ledr_q, ledr_d;
  logic                 trig_q, trig_d;
  logic                 to_q, to_d;
  logic                 busy_q, busy_d;
  logic [EDGE_W-1:0]    start_prev_q, start_prev_d;
  logic [EDGE_W-1:0]    button_prev_q, button_prev_d;
`ifdef FALSE_START_EN
  logic                 fs_q, fs_d;
`endif

  logic              start_edge;
  logic              button_edge;
  logic              rest_state;
  logic [LFSR_W-1:0] lfsr;
  logic [HOLD_W-1:0] hold_load;

  f1_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign start_edge  = io.start  & ~start_prev_q[0];
  assign button_edge = io.button & ~button_prev_q[0];
  assign hold_load   = HOLD_BASE + HOLD_W'(lfsr & HOLD_RAND_MASK);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ledr_d        = ledr_q;
    trig_d        = trig_q;
    to_d          = to_q;
    start_prev_d  = io.start;
    button_prev_d = io.button;
`ifdef FALSE_START_EN
    fs_d          = fs_q;
    rest_state    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FOUL);
`else
    rest_state    = (state_q == S_IDLE) || (state_q == S_DONE);
`endif

    // A start edge arms a new race; the tick in that same clk is deliberately dropped.
    if (start_edge && rest_state) begin
      state_d = S_LIGHTS;
      cnt_d   = '0;
      ledr_d  = LIGHT_CNT'(1);
      trig_d  = 1'b0;
      to_d    = 1'b0;
`ifdef FALSE_START_EN
      fs_d    = 1'b0;
`endif
    end
`ifdef FALSE_START_EN
    else if (button_edge && (state_q == S_LIGHTS || state_q == S_HOLD)) begin
      state_d = S_FOUL;
      ledr_d  = '1;
      fs_d    = 1'b1;
    end
`endif
    else begin
      case (state_q)
        S_LIGHTS: if (io.tick_ms) begin
          if (cnt_q == LIGHT_LAST) begin
            ledr_d = {ledr_q[LIGHT_CNT-2:0], 1'b1};
            cnt_d  = '0;
            if (ledr_q[LIGHT_CNT-2:0] == '1) begin
              state_d = S_HOLD;
              cnt_d   = CNT_W'(hold_load);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: if (io.tick_ms) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_GO;
            ledr_d  = '0;
            trig_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        // A press wins over a timeout landing in the same clk.
        S_GO: begin
          if (button_edge) begin
            state_d = S_DONE;
            trig_d  = 1'b0;
            to_d    = 1'b0;
          end else if (io.tick_ms) begin
            if (cnt_q == GO_LAST) begin
              state_d = S_DONE;
              trig_d  = 1'b0;
              to_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_GO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ledr_q        <= '0;
      trig_q        <= 1'b0;
      to_q          <= 1'b0;
      busy_q        <= 1'b0;
      start_prev_q  <= '0;
      button_prev_q <= '0;
`ifdef FALSE_START_EN
      fs_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ledr_q        <= ledr_d;
      trig_q        <= trig_d;
      to_q          <= to_d;
      busy_q        <= busy_d;
      start_prev_q  <= start_prev_d;
      button_prev_q <= button_prev_d;
`ifdef FALSE_START_EN
      fs_q          <= fs_d;
`endif
    end
  end

  assign io.ledr             = ledr_q;
  assign io.reaction_trigger = trig_q;
  assign io.timeout          = to_q;
  assign io.busy             = busy_q;
`ifdef FALSE_START_EN
  assign io.false_start      = fs_q;
`else
  assign io.false_start      = 1'b0;
`endif

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Scoreboard bench for f1_light_sequencer: two instances differing only in TIMEOUT_MS.
module tb_f1_light_sequencer;

  localparam int unsigned LMS  = 5;
  localparam int unsigned DMIN = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [11:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic button_i = 1'b0;
  logic tick_i = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  bit          fouled;

  f1_light_sequencer_if ifa ();
  f1_light_sequencer_if ifb ();

  assign ifa.start   = start_i;
  assign ifa.button  = button_i;
  assign ifa.tick_ms = tick_i;
  assign ifb.start   = start_i;
  assign ifb.button  = button_i;
  assign ifb.tick_ms = tick_i;

  f1_light_sequencer #(
    .LIGHT_MS(LMS), .DELAY_MIN_MS(DMIN), .TIMEOUT_MS(250), .LFSR_SEED(SEED)
  ) dut_a (.clk(clk), .rst(rst), .io(ifa));

  f1_light_sequencer #(
    .LIGHT_MS(LMS), .DELAY_MIN_MS(DMIN), .TIMEOUT_MS(20), .LFSR_SEED(SEED)
  ) dut_b (.clk(clk), .rst(rst), .io(ifb));

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT saw at the most recent edge.
  function automatic logic [15:0] ref_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= ref_step(m_lfsr);
    end
  end

  function automatic logic [11:0] v(input logic busy, input logic to, input logic fs,
                                    input logic trig, input logic [7:0] led);
    return {busy, to, fs, trig, led};
  endfunction

  function automatic logic [11:0] obs(input int unsigned sel);
    if (sel == 0)
      return {ifa.busy, ifa.timeout, ifa.false_start, ifa.reaction_trigger, ifa.ledr};
    return {ifb.busy, ifb.timeout, ifb.false_start, ifb.reaction_trigger, ifb.ledr};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (busy,to,fs,trig,ledr)", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input int unsigned sel, input logic [11:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic both(input string tag, input logic [11:0] e);
    push(tag, 0, e);
    push(tag, 1, e);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq($sformatf("%s[dut%0d]", x.tag, x.sel), obs(x.sel), x.exp);
    end
  endtask

  task automatic cyc(input logic s, input logic b, input logic t);
    start_i  = s;
    button_i = b;
    tick_i   = t;
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic race(input bit probe, input bit rst_hold, input int unsigned mode,
                      output bit foul);
    logic [7:0]  cur;
    logic        st;
    logic        b;
    int unsigned hold_n;
    foul = 1'b0;
    cyc(0, 0, 0);
    both("race_start", v(1, 0, 0, 0, 8'h01));
    cyc(1, 0, 1);
    cur = 8'h01;
    st  = 1'b0;
    b   = 1'b0;
    for (int unsigned l = 1; l < 8; l++) begin
      for (int unsigned k = 1; k <= LMS; k++) begin
        if (probe && cur == 8'h07 && k == 2) begin
          b = 1'b1;
`ifdef FALSE_START_EN
          both("foul", v(0, 0, 1, 0, 8'hFF));
          cyc(st, b, 0);
          for (int i = 0; i < 3; i++) begin
            both("foul_hold", v(0, 0, 1, 0, 8'hFF));
            cyc(0, 0, 1);
          end
          foul = 1'b1;
          return;
`endif
        end
        both("light_gap", v(1, 0, 0, 0, cur));
        cyc(st, b, 0);
        st = ~st;
        if (k == LMS) cur = {cur[6:0], 1'b1};
        both("light_tick", v(1, 0, 0, 0, cur));
        cyc(st, b, 1);
        st = ~st;
      end
      if (l == 4) b = 1'b0;
    end

    hold_n = DMIN + int'(m_prev[10:0]);
    both("hold_gap", v(1, 0, 0, 0, 8'hFF));
    cyc(0, 0, 0);
    for (int unsigned i = 1; i <= hold_n; i++) begin
      if (rst_hold && i == 2) begin
        rst = 1'b1;
        #2;
        both("rst_mid_hold", v(0, 0, 0, 0, 8'h00));
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (i < hold_n) both("hold_tick", v(1, 0, 0, 0, 8'hFF));
      else            both("lights_out", v(1, 0, 0, 1, 8'h00));
      cyc(0, 0, 1);
    end

    if (mode == 0) begin
      for (int unsigned i = 1; i <= 200; i++) begin
        push("go", 0, v(1, 0, 0, 1, 8'h00));
        if (i < 20)       push("go", 1, v(1, 0, 0, 1, 8'h00));
        else if (i == 20) push("timeout", 1, v(0, 1, 0, 0, 8'h00));
        else              push("timeout_hold", 1, v(0, 1, 0, 0, 8'h00));
        cyc(i == 10, 0, 1);
      end
      push("press", 0, v(0, 0, 0, 0, 8'h00));
      push("timeout_hold", 1, v(0, 1, 0, 0, 8'h00));
      cyc(0, 1, 0);
      for (int i = 0; i < 3; i++) begin
        push("done_hold", 0, v(0, 0, 0, 0, 8'h00));
        push("timeout_hold", 1, v(0, 1, 0, 0, 8'h00));
        cyc(0, 1, 1);
      end
    end else begin
      for (int unsigned i = 1; i < 20; i++) begin
        both("go", v(1, 0, 0, 1, 8'h00));
        cyc(0, 0, 1);
      end
      both("press_on_last_tick", v(0, 0, 0, 0, 8'h00));
      cyc(0, 1, 1);
      both("done_hold", v(0, 0, 0, 0, 8'h00));
      cyc(0, 1, 1);
      both("done_hold", v(0, 0, 0, 0, 8'h00));
      cyc(0, 0, 1);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    both("reset", v(0, 0, 0, 0, 8'h00));
    cyc(0, 0, 1);
    both("reset", v(0, 0, 0, 0, 8'h00));
    cyc(1, 1, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      both("idle", v(0, 0, 0, 0, 8'h00));
      cyc(0, i == 1, 1);
    end

    race(1, 0, 0, fouled);
    if (fouled) race(0, 0, 0, fouled);
    race(0, 1, 0, fouled);
    race(0, 0, 1, fouled);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f1_light_sequencer.md
F1_LIGHT_SEQUENCER -- requirements
Module: f1_light_sequencer

Interface
REQ-001 SHALL have parameter LIGHT_MS, default 500, ms between successive lights.
REQ-002 SHALL have parameter DELAY_MIN_MS, default 250, minimum random hold after the 8th light.
REQ-003 SHALL have parameter TIMEOUT_MS, default 9999, maximum GO duration before abort.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (non-zero).
REQ-005 clk  in  1  system clock; all state changes on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 tick_ms  in  1  one-clk enable pulse every 1 ms.
REQ-008 start  in  1  synchronous, debounced level; rising edge requests a race.
REQ-009 button  in  1  synchronous, debounced level; rising edge is a driver press.
REQ-010 ledr  out  8  start-light pattern, bit0 lit first.
REQ-011 reaction_trigger  out  1  high from lights-out until press or timeout; feeds the downstream reaction counter.
REQ-012 false_start  out  1  high in FOUL.
REQ-013 timeout  out  1  high in DONE when GO ended without a press.
REQ-014 busy  out  1  high in LIGHTS, HOLD, GO.

Function
REQ-015 States SHALL be IDLE, LIGHTS, HOLD, GO, DONE, FOUL; all outputs registered.
REQ-016 Start and button edges SHALL be detected from a one-clk-delayed copy; edge is seen the cycle the level first reads 1.
REQ-017 IDLE, DONE or FOUL with start edge: next clk -> LIGHTS, ledr=8'h01, ms counter=0, false_start=0, timeout=0.
REQ-018 Start edge in LIGHTS/HOLD/GO SHALL be ignored.
REQ-019 LIGHTS: ms counter increments on tick_ms; on the tick where it reaches LIGHT_MS-1: ledr <= {ledr[6:0],1'b1}, counter=0.
REQ-020 The clk ledr becomes 8'hFF: -> HOLD, hold counter loaded with DELAY_MIN_MS + lfsr[10:0] (range 250..2297 at defaults, 12-bit result).
REQ-021 HOLD: hold counter decrements on tick_ms; on the tick it reaches 0: ledr=8'h00, reaction_trigger=1, -> GO, counter=0.
REQ-022 GO: counter increments on tick_ms; button edge -> DONE, reaction_trigger=0 next clk, timeout=0.
REQ-023 GO: counter reaching TIMEOUT_MS-1 without press -> DONE, reaction_trigger=0, timeout=1.
REQ-024 Button edge and final timeout tick in the same clk SHALL resolve as a press (timeout=0).
REQ-025 tick_ms with start edge in same clk from IDLE: the tick SHALL NOT count toward the first light.
REQ-026 LFSR: 16-bit Galois, mask 16'hB400, advances every clk in every state including IDLE.
REQ-027 DONE/FOUL SHALL hold outputs until a start edge.

Reset
REQ-028 rst SHALL force IDLE, ledr=0, reaction_trigger=0, false_start=0, timeout=0, busy=0, counters=0, edge registers=0, lfsr=LFSR_SEED, at any time including mid-race.

Configuration
REQ-029 Macro FALSE_START_EN defined: button edge in LIGHTS or HOLD -> FOUL next clk, false_start=1, ledr=8'hFF, reaction_trigger never asserted for that race.
REQ-030 FALSE_START_EN undefined: button ignored outside GO; FOUL state and false_start logic absent, false_start tied 0.

Structure
REQ-031 Package f1_pkg SHALL hold the state enum typedef, light count 8, LFSR mask 16'hB400 and edge/counter widths.
REQ-032 LFSR SHALL be sub-module f1_lfsr16 (clk, rst, seed parameter, 16-bit q); rest stays in one module.

Verification
REQ-033 LIGHT_MS=5, DELAY_MIN_MS=3: start edge -> ledr 01,03,07..FF at 5-ms steps; HOLD length = 3 + lfsr[10:0] ticks, checked against reference LFSR model.
REQ-034 In GO, button edge after 200 ticks -> reaction_trigger falls next clk, state DONE, timeout=0.
REQ-035 TIMEOUT_MS=20, no press -> reaction_trigger high exactly 20 ticks, then timeout=1.
REQ-036 FALSE_START_EN: button edge with ledr=8'h07 -> false_start=1, ledr=FF, reaction_trigger stays 0; undefined: same stimulus ignored, race completes.
REQ-037 rst pulse during HOLD -> all outputs 0, IDLE; next start edge restarts at ledr=8'h01.
REQ-038 Button edge coincident with last timeout tick -> DONE, timeout=0; start edge during LIGHTS -> no change.
